// File: rtl/duck_sprite_fetch_if.sv
// Frame RAM read bus between the duck sprite fetch engine (master) and the sprite-sheet RAM (slave).
interface duck_sprite_fetch_if;
  logic [18:0] read_address;
  logic [4:0]  ram_data;

  modport master (output read_address, input ram_data);
  modport slave  (input read_address, output ram_data);
endinterface

// File: rtl/duck_sprite_fetch.sv
// Duck sprite-sheet read engine: scan-coordinate to frame RAM address, animation sequencer, 2-cycle pixel alignment.
// Optional horizontal mirroring is built only when SPRITE_MIRROR_EN is defined.
module duck_sprite_fetch #(
  parameter int SPR_W       = 20,
  parameter int SPR_H       = 20,
  parameter int FLY_FRAMES  = 3,
  parameter int HOLD        = 8,
  parameter int SHOT_HOLD   = 30,
  parameter int FALL_HOLD   = 60,
  parameter int TRANSPARENT = 0
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_start,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic [9:0]          sprite_x,
  input  logic [9:0]          sprite_y,
  input  logic                spawn,
  input  logic                hit,
  input  logic                flip_h,
  duck_sprite_fetch_if.master ram,
  output logic [2:0]          pixel_idx,
  output logic                pixel_on,
  output logic                busy
);

  localparam int FRAME_W  = $clog2(FLY_FRAMES + 2);
  localparam int HOLD_MAX = (HOLD > SHOT_HOLD) ? ((HOLD > FALL_HOLD) ? HOLD : FALL_HOLD)
                                               : ((SHOT_HOLD > FALL_HOLD) ? SHOT_HOLD : FALL_HOLD);
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [FRAME_W-1:0] ANIM_LAST  = FRAME_W'(FLY_FRAMES - 1);
  localparam logic [FRAME_W-1:0] SHOT_FRAME = FRAME_W'(FLY_FRAMES);
  localparam logic [FRAME_W-1:0] FALL_FRAME = FRAME_W'(FLY_FRAMES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD - 1);
  localparam logic [HOLD_W-1:0]  SHOT_LAST  = HOLD_W'(SHOT_HOLD - 1);
  localparam logic [HOLD_W-1:0]  FALL_LAST  = HOLD_W'(FALL_HOLD - 1);
  localparam logic [9:0]         SPR_W_V    = 10'(SPR_W);
  localparam logic [9:0]         SPR_H_V    = 10'(SPR_H);
  localparam logic [18:0]        ROW_STEP   = 19'(SPR_W);
  localparam logic [18:0]        FRAME_SIZE = 19'(SPR_W * SPR_H);
  localparam logic [2:0]         TRANSP_V   = 3'(TRANSPARENT);

  typedef enum logic [1:0] {HIDDEN, FLY, SHOT, FALL} state_t;

  state_t              state;
  logic [FRAME_W-1:0]  anim_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                spawn_pend;
  logic                hit_pend;
  logic                spawn_req;
  logic                hit_req;
  logic [FRAME_W-1:0]  frame;
  logic [9:0]          lx;
  logic [9:0]          ly;
  logic [9:0]          lx_addr;
  logic                in_box;
  logic [18:0]         addr_next;
  logic [18:0]         read_address_q;
  logic                in_box_d1;
  logic                busy_d1;
  logic                in_box_d2;
  logic                busy_d2;
  logic                unused_ram_bits;

  // A request landing on the same cycle as frame_start still counts for that blank.
  assign spawn_req = spawn_pend | spawn;
  assign hit_req   = hit_pend | hit;
  assign busy      = (state != HIDDEN);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= HIDDEN;
      anim_cnt   <= '0;
      hold_cnt   <= '0;
      spawn_pend <= 1'b0;
      hit_pend   <= 1'b0;
    end else if (frame_start) begin
      spawn_pend <= 1'b0;
      hit_pend   <= 1'b0;
      case (state)
        HIDDEN: begin
          if (spawn_req) begin
            state    <= FLY;
            anim_cnt <= '0;
            hold_cnt <= '0;
          end
        end
        FLY: begin
          if (hit_req) begin
            state    <= SHOT;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            anim_cnt <= (anim_cnt == ANIM_LAST) ? '0 : anim_cnt + 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        SHOT: begin
          if (hold_cnt == SHOT_LAST) begin
            state    <= FALL;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          if (hold_cnt == FALL_LAST) begin
            state    <= HIDDEN;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end else begin
      if (spawn && state == HIDDEN) spawn_pend <= 1'b1;
      if (hit && state == FLY)      hit_pend   <= 1'b1;
    end
  end

  always_comb begin
    frame = '0;
    case (state)
      FLY:     frame = anim_cnt;
      SHOT:    frame = SHOT_FRAME;
      FALL:    frame = FALL_FRAME;
      default: frame = '0;
    endcase
  end

  // Unsigned wrap makes coordinates left of / above the sprite look huge, so one compare rejects both sides.
  assign lx     = DrawX - sprite_x;
  assign ly     = DrawY - sprite_y;
  assign in_box = (lx < SPR_W_V) && (ly < SPR_H_V);

`ifdef SPRITE_MIRROR_EN
  assign lx_addr = flip_h ? (SPR_W_V - 10'd1 - lx) : lx;
`else
  logic unused_flip_h;
  assign unused_flip_h = flip_h;
  assign lx_addr       = lx;
`endif

  assign addr_next = 19'(frame) * FRAME_SIZE + 19'(ly) * ROW_STEP + 19'(lx_addr);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address_q <= '0;
      in_box_d1      <= 1'b0;
      busy_d1        <= 1'b0;
      in_box_d2      <= 1'b0;
      busy_d2        <= 1'b0;
    end else begin
      if (in_box) read_address_q <= addr_next;
      in_box_d1 <= in_box;
      busy_d1   <= busy;
      in_box_d2 <= in_box_d1;
      busy_d2   <= busy_d1;
    end
  end

  assign ram.read_address = read_address_q;

  // Only the low three bits of the RAM word carry the palette index.
  assign unused_ram_bits = ^ram.ram_data[4:3];
  assign pixel_idx       = in_box_d2 ? ram.ram_data[2:0] : 3'd0;
  assign pixel_on        = in_box_d2 && busy_d2 && (ram.ram_data[2:0] != TRANSP_V);

endmodule

// File: tb/tb_duck_sprite_fetch.sv
// Directed bench for duck_sprite_fetch; the RAM model returns {2'b11, address[2:0]} one edge after the address.
module tb_duck_sprite_fetch;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] DrawX = 10'd100;
  logic [9:0] DrawY = 10'd50;
  logic [9:0] sprite_x = 10'd100;
  logic [9:0] sprite_y = 10'd50;
  logic       spawn = 1'b0;
  logic       hit = 1'b0;
  logic       flip_h = 1'b0;
  logic [2:0] pixel_idx;
  logic       pixel_on;
  logic       busy;
  int         errors = 0;
  int         checks = 0;
  int         mirror_expect;

  duck_sprite_fetch_if ram_bus ();

  duck_sprite_fetch dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .spawn       (spawn),
    .hit         (hit),
    .flip_h      (flip_h),
    .ram         (ram_bus.master),
    .pixel_idx   (pixel_idx),
    .pixel_on    (pixel_on),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  // Synchronous-read frame RAM stand-in; upper bits set to prove they are ignored.
  always @(posedge Clk) ram_bus.ram_data <= {2'b11, ram_bus.read_address[2:0]};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hold a coordinate for two edges so address and aligned pixel outputs both refer to it.
  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y);
    DrawX = x;
    DrawY = y;
    tick(2);
  endtask

  task automatic pulseFrame(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      tick(1);
    end
  endtask

  task automatic pulseSpawn();
    spawn = 1'b1;
    tick(1);
    spawn = 1'b0;
  endtask

  task automatic pulseHit();
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
  endtask

  initial begin
    tick(3);
    checkOutput("reset_pixel_on", int'(pixel_on), 0);
    checkOutput("reset_addr", int'(ram_bus.read_address), 0);
    checkOutput("reset_busy", int'(busy), 0);
    Reset_n = 1'b1;

    applyStimulus(10'd105, 10'd52);
    checkOutput("hidden_idx", int'(pixel_idx), 5);
    checkOutput("hidden_pixel_on", int'(pixel_on), 0);
    pulseFrame(3);
    checkOutput("no_spawn_busy", int'(busy), 0);

    pulseSpawn();
    pulseFrame(1);
    checkOutput("spawn_busy", int'(busy), 1);
    applyStimulus(10'd100, 10'd50);
    checkOutput("origin_addr", int'(ram_bus.read_address), 0);
    DrawX = 10'd105;
    DrawY = 10'd52;
    tick(1);
    checkOutput("addr_one_edge", int'(ram_bus.read_address), 45);
    tick(1);
    checkOutput("fly_pixel_on", int'(pixel_on), 1);
    checkOutput("fly_pixel_idx", int'(pixel_idx), 5);

    applyStimulus(10'd100, 10'd52);
    checkOutput("transp_addr", int'(ram_bus.read_address), 40);
    checkOutput("transp_pixel_on", int'(pixel_on), 0);

    applyStimulus(10'd99, 10'd52);
    checkOutput("left_hold_addr", int'(ram_bus.read_address), 40);
    checkOutput("left_pixel_on", int'(pixel_on), 0);
    checkOutput("left_pixel_idx", int'(pixel_idx), 0);
    applyStimulus(10'd120, 10'd52);
    checkOutput("right_pixel_on", int'(pixel_on), 0);
    applyStimulus(10'd119, 10'd69);
    checkOutput("corner_addr", int'(ram_bus.read_address), 399);
    checkOutput("corner_pixel_on", int'(pixel_on), 1);
    checkOutput("corner_pixel_idx", int'(pixel_idx), 7);
    applyStimulus(10'd100, 10'd70);
    checkOutput("below_pixel_on", int'(pixel_on), 0);

    sprite_x = 10'd1015;
    applyStimulus(10'd10, 10'd50);
    checkOutput("wrap_in_addr", int'(ram_bus.read_address), 19);
    checkOutput("wrap_in_on", int'(pixel_on), 1);
    applyStimulus(10'd11, 10'd50);
    checkOutput("wrap_out_on", int'(pixel_on), 0);
    applyStimulus(10'd1014, 10'd50);
    checkOutput("wrap_left_on", int'(pixel_on), 0);
    sprite_x = 10'd100;

    pulseFrame(8);
    applyStimulus(10'd100, 10'd50);
    checkOutput("flap1_addr", int'(ram_bus.read_address), 400);
    pulseFrame(8);
    applyStimulus(10'd100, 10'd50);
    checkOutput("flap2_addr", int'(ram_bus.read_address), 800);
    pulseFrame(8);
    applyStimulus(10'd101, 10'd50);
    checkOutput("flap_wrap_addr", int'(ram_bus.read_address), 1);

`ifdef SPRITE_MIRROR_EN
    mirror_expect = 19;
`else
    mirror_expect = 0;
`endif
    flip_h = 1'b1;
    applyStimulus(10'd100, 10'd50);
    checkOutput("mirror_addr", int'(ram_bus.read_address), mirror_expect);
    flip_h = 1'b0;

    pulseHit();
    pulseFrame(1);
    applyStimulus(10'd100, 10'd50);
    checkOutput("shot_addr", int'(ram_bus.read_address), 1200);
    checkOutput("shot_busy", int'(busy), 1);
    pulseSpawn();
    pulseFrame(29);
    applyStimulus(10'd101, 10'd50);
    checkOutput("shot_last_addr", int'(ram_bus.read_address), 1201);
    pulseFrame(1);
    applyStimulus(10'd100, 10'd50);
    checkOutput("fall_addr", int'(ram_bus.read_address), 1600);
    pulseFrame(59);
    checkOutput("fall_last_busy", int'(busy), 1);
    pulseFrame(1);
    checkOutput("fall_done_busy", int'(busy), 0);
    applyStimulus(10'd101, 10'd50);
    checkOutput("hidden_again_addr", int'(ram_bus.read_address), 1);
    checkOutput("hidden_again_on", int'(pixel_on), 0);
    pulseFrame(1);
    checkOutput("spawn_in_shot_ignored", int'(busy), 0);

    pulseHit();
    pulseFrame(1);
    checkOutput("hit_hidden_ignored", int'(busy), 0);
    spawn = 1'b1;
    hit = 1'b1;
    tick(1);
    spawn = 1'b0;
    hit = 1'b0;
    pulseFrame(1);
    checkOutput("spawn_hit_busy", int'(busy), 1);
    pulseFrame(1);
    applyStimulus(10'd102, 10'd50);
    checkOutput("spawn_hit_frame0", int'(ram_bus.read_address), 2);

    pulseSpawn();
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_addr", int'(ram_bus.read_address), 0);
    checkOutput("midreset_pixel_on", int'(pixel_on), 0);
    tick(2);
    Reset_n = 1'b1;
    pulseFrame(2);
    checkOutput("after_reset_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
